mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised MEM/WB pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush, and bubble-safe control outputs. It sits between the data-memory stage and register write-back. It replaces the fixed 32-bit flush-only stage register with back-pressure support, so write-back can stall without losing in-flight results. Payload fields (instruction, ALU result, memory data, write-register) are packed by the instantiating stage into `InData`.

## Interface
- `DATA_W`, 128: payload width in bits (instruction, ALU result, memory data, write-register, 32 bits each).
- `CTRL_W`, 2: control width; bit1 = MemToReg, bit0 = RegWrite.
- `BUBBLE_CTRL`, 2'b10: control value presented whenever no valid entry is output (MemToReg=1, RegWrite=0).
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Flush` in 1: synchronous kill of all held entries.
- `InValid` in 1: upstream entry valid.
- `InReady` out 1: stage can accept; registered.
- `InCtrl` in `CTRL_W`: upstream control.
- `InData` in `DATA_W`: upstream payload.
- `OutValid` out 1: output entry valid.
- `OutReady` in 1: write-back consumes.
- `OutCtrl` out `CTRL_W`: output control.
- `OutData` out `DATA_W`: output payload.
- `StallCount` out 16: only with `MEM_WB_PERF_EN`.
- `FlushCount` out 16: only with `MEM_WB_PERF_EN`.

## Operation
- Accept = `InValid & InReady`; Drain = `OutValid & OutReady`; both are sampled at the rising edge.
- The block holds a main register (drives the outputs) and a skid register, tracked by a state machine with states EMPTY, ONE, TWO.
- Transitions from EMPTY:
  - Accept: load main from input; go to ONE.
  - Otherwise: stay in EMPTY.
- Transitions from ONE:
  - Accept and Drain: load main from input; stay in ONE.
  - Accept without Drain: load skid from input; go to TWO.
  - Drain without Accept: go to EMPTY.
  - Otherwise: hold in ONE.
- Transitions from TWO:
  - Drain: load main from skid; go to ONE.
  - Otherwise: hold in TWO.
  - Accept cannot occur in TWO because `InReady`=0.
- Output and ready relations:
  - `OutValid` = (state != EMPTY).
  - `InReady` = (next state != TWO); it is registered, never combinational from `OutReady`.
- On entering EMPTY by drain: `OutCtrl` <= `BUBBLE_CTRL`; `OutData` holds its last value.
- Flush: the next state is EMPTY regardless of Accept or Drain, and flush overrides both.
  - `OutCtrl` <= `BUBBLE_CTRL`, `OutData` <= 0, `InReady` <= 1.
  - An entry offered in the same cycle as Flush is dropped.
- Entries leave in strict arrival order; none is duplicated or reordered.

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - State EMPTY.
  - `OutValid`=0, `InReady`=1, `OutCtrl`=`BUBBLE_CTRL`, `OutData`=0.
  - Skid cleared to 0; counters 0.
- Latency: an entry accepted at edge N appears on `OutData` after edge N if the block was EMPTY, or was ONE with Drain at N.
- Throughput: one entry per cycle when `OutReady` is held high.
- Back-pressure: after `OutReady` falls, at most one further Accept occurs (into the skid); `InReady` is 0 from the next cycle.
- Recovery: `InReady` returns to 1 one cycle after the Drain that leaves TWO.
- Reset asserted mid-operation discards both entries immediately, without waiting for a clock.

## Configuration
- `MEM_WB_PERF_EN` defined:
  - `StallCount` increments each cycle with `OutValid & ~OutReady`.
  - `FlushCount` increments each cycle with `Flush` while state != EMPTY.
  - Both counters are 16-bit, saturate at 16'hFFFF, and are cleared only by reset; flush does not clear them.
- `MEM_WB_PERF_EN` undefined: both ports and the counter logic are absent, and all other behaviour is identical.

## Test plan
- Streaming: 8 entries `InData`=1..8, `InCtrl`=2'b01, `OutReady`=1 throughout → `OutData`=1..8 on consecutive cycles, one cycle after each accept; `InReady` stays 1.
- Back-pressure: `OutReady`=0 after entry 1 is output while entries 2, 3 are offered → 2 is accepted, `InReady`=0, 3 is held upstream. Releasing `OutReady` → outputs 1, 2, 3 in order, with no loss or duplicate.
- Flush in TWO concurrent with `InValid`=1 → next cycle `OutValid`=0, `OutCtrl`=2'b10, `OutData`=0, `InReady`=1; the offered entry never appears.
- Drain to empty → `OutCtrl`=2'b10 (RegWrite=0) while `OutData` holds the last value.
- Async reset pulse mid-stream between clock edges → outputs take reset values before the next edge.
- With `MEM_WB_PERF_EN`: 5 stall cycles and 2 flushes of a non-empty stage → `StallCount`=5, `FlushCount`=2. Forcing 70000 stall cycles → `StallCount`=16'hFFFF.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline stage register with a valid/ready handshake and a two-entry
// skid buffer (main + skid). Write-back can stall without losing in-flight
// results. A synchronous Flush kills every held entry. Whenever no valid entry
// is presented, the control output carries BUBBLE_CTRL, so RegWrite is 0.
//
// Parameters:
//   DATA_W      payload width (instruction, ALU result, mem data, write-reg)
//   CTRL_W      control width; bit1 = MemToReg, bit0 = RegWrite
//   BUBBLE_CTRL control value presented while OutValid is 0
//
// Ports:
//   Clock      in   single clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Flush      in   synchronous kill of all held entries
//   InValid    in   upstream entry valid
//   InReady    out  stage can accept (registered)
//   InCtrl     in   upstream control
//   InData     in   upstream payload
//   OutValid   out  output entry valid (registered)
//   OutReady   in   write-back consumes the output entry
//   OutCtrl    out  output control (registered)
//   OutData    out  output payload (registered)
//   StallCount out  cycles with OutValid & ~OutReady, saturating (optional)
//   FlushCount out  flushes of a non-empty stage, saturating (optional)
//
// Optional feature macro: MEM_WB_PERF_EN adds StallCount/FlushCount.
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int unsigned       DATA_W      = 128,
  parameter int unsigned       CTRL_W      = 2,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = 2'b10
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CTRL_W-1:0] InCtrl,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [DATA_W-1:0] OutData
`ifdef MEM_WB_PERF_EN
  ,
  output logic [15:0]       StallCount,
  output logic [15:0]       FlushCount
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;

  logic                accept_s;
  logic                drain_s;

  // Handshake events as seen at the coming rising edge.
  always_comb begin
    accept_s = InValid & in_ready_q;
    drain_s  = out_valid_q & OutReady;
  end

  // Next-state, next-payload and registered-output computation.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (Flush) begin
      // Flush wins over accept and drain; an entry offered now is dropped.
      state_d     = ST_EMPTY;
      main_ctrl_d = BUBBLE_CTRL;
      main_data_d = {DATA_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
      skid_data_d = {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            main_ctrl_d = InCtrl;
            main_data_d = InData;
            state_d     = ST_ONE;
          end else begin
            state_d     = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            main_ctrl_d = InCtrl;
            main_data_d = InData;
            state_d     = ST_ONE;
          end else if (accept_s) begin
            // Output is stalled: park the newcomer behind the main entry.
            skid_ctrl_d = InCtrl;
            skid_data_d = InData;
            state_d     = ST_TWO;
          end else if (drain_s) begin
            // Going empty: kill RegWrite but leave the payload as it was.
            main_ctrl_d = BUBBLE_CTRL;
            state_d     = ST_EMPTY;
          end else begin
            state_d     = ST_ONE;
          end
        end
        ST_TWO: begin
          if (drain_s) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end else begin
            state_d     = ST_TWO;
          end
        end
        default: begin
          // Illegal encoding: fall back to a safe, empty stage.
          state_d     = ST_EMPTY;
          main_ctrl_d = BUBBLE_CTRL;
          main_data_d = {DATA_W{1'b0}};
          skid_ctrl_d = {CTRL_W{1'b0}};
          skid_data_d = {DATA_W{1'b0}};
        end
      endcase
    end

    // Ready and valid are derived from the next state so both stay registered.
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State, handshake and payload registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl_q <= BUBBLE_CTRL;
      main_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign OutCtrl  = main_ctrl_q;
  assign OutData  = main_data_q;

`ifdef MEM_WB_PERF_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Saturating performance counters; only reset clears them.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (out_valid_q && !OutReady && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
    if (Flush && (state_q != ST_EMPTY) && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign StallCount = stall_count_q;
  assign FlushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Scoreboard bench for mem_wb_stage. Every accepted entry is pushed to a queue;
// each falling edge compares the DUT outputs with the queue head and checks
// OutValid/InReady against the queue occupancy. Directed checks cover reset,
// back-pressure, flush, drain-to-empty, async reset and (with MEM_WB_PERF_EN)
// the saturating counters.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int         DATA_W = 128;
  localparam int         CTRL_W = 2;
  localparam logic [1:0] BUBBLE = 2'b10;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic              Flush;
  logic              InValid;
  logic              InReady;
  logic [CTRL_W-1:0] InCtrl;
  logic [DATA_W-1:0] InData;
  logic              OutValid;
  logic              OutReady;
  logic [CTRL_W-1:0] OutCtrl;
  logic [DATA_W-1:0] OutData;
`ifdef MEM_WB_PERF_EN
  logic [15:0]       StallCount;
  logic [15:0]       FlushCount;
`endif

  int checks_total  = 0;
  int checks_passed = 0;
  int drained_cnt   = 0;
  int base_cnt;

  logic [CTRL_W+DATA_W-1:0] sb_q[$];

  mem_wb_stage #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .BUBBLE_CTRL(BUBBLE)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Flush     (Flush),
    .InValid   (InValid),
    .InReady   (InReady),
    .InCtrl    (InCtrl),
    .InData    (InData),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutCtrl   (OutCtrl),
    .OutData   (OutData)
`ifdef MEM_WB_PERF_EN
    ,
    .StallCount(StallCount),
    .FlushCount(FlushCount)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: compare on the falling edge, then apply the handshake
  // that the coming rising edge will perform.
  always @(negedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sb_q.delete();
    end else begin
      check_val("out_valid", 130'(OutValid), 130'(sb_q.size() != 0));
      check_val("in_ready", 130'(InReady), 130'(sb_q.size() < 2));
      if (sb_q.size() != 0) begin
        check_val("out_entry", {OutCtrl, OutData}, sb_q[0]);
      end else begin
        check_val("bubble_ctrl", 130'(OutCtrl), 130'(BUBBLE));
      end
      if (Flush) begin
        sb_q.delete();
      end else begin
        if (OutValid && OutReady && (sb_q.size() != 0)) begin
          void'(sb_q.pop_front());
          drained_cnt <= drained_cnt + 1;
        end
        if (InValid && InReady) begin
          sb_q.push_back({InCtrl, InData});
        end
      end
    end
  end

  // Offer one entry and hold it until it is accepted (bounded).
  task automatic send(input logic [1:0] c, input logic [127:0] d);
    bit done = 1'b0;
    InValid = 1'b1;
    InCtrl  = c;
    InData  = d;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge Clock);
      done = InReady;
      @(posedge Clock);
      #1;
    end
    check_val("send_accepted", 130'(done), 130'(1));
    InValid = 1'b0;
  endtask

  // Wait (bounded) until the stage reports empty.
  task automatic wait_empty();
    bit empty = 1'b0;
    for (int k = 0; k < 64 && !empty; k++) begin
      @(negedge Clock);
      empty = !OutValid;
    end
    check_val("wait_empty", 130'(empty), 130'(1));
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset_n  = 1'b0;
    Flush    = 1'b0;
    InValid  = 1'b0;
    InCtrl   = 2'b00;
    InData   = 128'd0;
    OutReady = 1'b0;
    #12;
    check_val("rst_out_valid", 130'(OutValid), 130'(0));
    check_val("rst_in_ready", 130'(InReady), 130'(1));
    check_val("rst_out_ctrl", 130'(OutCtrl), 130'(BUBBLE));
    check_val("rst_out_data", 130'(OutData), 130'(0));
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;

    // Streaming: one entry per cycle with OutReady held high.
    OutReady = 1'b1;
    base_cnt = drained_cnt;
    for (int i = 1; i <= 8; i++) begin
      send(2'b01, 128'(i));
    end
    wait_empty();
    check_val("stream_drained", 130'(drained_cnt - base_cnt), 130'(8));
    check_val("stream_last_data", 130'(OutData), 130'(8));

    // Back-pressure: entry 2 goes to the skid, entry 3 waits upstream.
    base_cnt = drained_cnt;
    send(2'b01, 128'd11);
    OutReady = 1'b0;
    send(2'b01, 128'd12);
    InValid = 1'b1;
    InCtrl  = 2'b01;
    InData  = 128'd13;
    repeat (3) @(posedge Clock);
    #1;
    check_val("bp_in_ready", 130'(InReady), 130'(0));
    check_val("bp_out_data", 130'(OutData), 130'(11));
    OutReady = 1'b1;
    send(2'b01, 128'd13);
    wait_empty();
    check_val("bp_drained", 130'(drained_cnt - base_cnt), 130'(3));
    // Drain to empty: RegWrite killed, payload holds last value.
    check_val("empty_ctrl", 130'(OutCtrl), 130'(BUBBLE));
    check_val("empty_data", 130'(OutData), 130'(13));

    // Flush in TWO with a concurrent offer.
    OutReady = 1'b0;
    send(2'b01, 128'd21);
    send(2'b01, 128'd22);
    InValid = 1'b1;
    InCtrl  = 2'b01;
    InData  = 128'd23;
    Flush   = 1'b1;
    @(posedge Clock);
    #1;
    Flush   = 1'b0;
    InValid = 1'b0;
    check_val("flush_out_valid", 130'(OutValid), 130'(0));
    check_val("flush_out_ctrl", 130'(OutCtrl), 130'(BUBBLE));
    check_val("flush_out_data", 130'(OutData), 130'(0));
    check_val("flush_in_ready", 130'(InReady), 130'(1));
    OutReady = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
    check_val("flush_no_ghost", 130'(OutValid), 130'(0));

    // Async reset between edges with two entries held.
    OutReady = 1'b0;
    send(2'b01, 128'd31);
    send(2'b01, 128'd32);
    #1;
    Reset_n = 1'b0;
    #1;
    check_val("arst_out_valid", 130'(OutValid), 130'(0));
    check_val("arst_in_ready", 130'(InReady), 130'(1));
    check_val("arst_out_ctrl", 130'(OutCtrl), 130'(BUBBLE));
    check_val("arst_out_data", 130'(OutData), 130'(0));
    #1;
    Reset_n = 1'b1;

`ifdef MEM_WB_PERF_EN
    check_val("perf_stall_rst", 130'(StallCount), 130'(0));
    check_val("perf_flush_rst", 130'(FlushCount), 130'(0));
    // Five stall cycles, the last coinciding with the first flush.
    OutReady = 1'b0;
    send(2'b01, 128'd41);
    repeat (4) @(posedge Clock);
    #1;
    Flush = 1'b1;
    @(posedge Clock);
    #1;
    Flush = 1'b0;
    // Second flush of a non-empty stage, no stall (OutReady high).
    OutReady = 1'b1;
    send(2'b01, 128'd42);
    Flush = 1'b1;
    @(posedge Clock);
    #1;
    // Flush of an empty stage is not counted.
    @(posedge Clock);
    #1;
    Flush = 1'b0;
    check_val("perf_stall_5", 130'(StallCount), 130'(5));
    check_val("perf_flush_2", 130'(FlushCount), 130'(2));
    // Saturation.
    OutReady = 1'b0;
    send(2'b01, 128'd43);
    repeat (70000) @(posedge Clock);
    #1;
    check_val("perf_stall_sat", 130'(StallCount), 130'(16'hFFFF));
    check_val("perf_flush_keep", 130'(FlushCount), 130'(2));
    OutReady = 1'b1;
    wait_empty();
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
